// File: rtl/ddr_wr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// GLOBAL_PARAM: shared datapath geometry for the DDR write controller.
//   DATA_W     - width of one reduced output lane (signed byte)
//   RES_W      - width of one incoming result lane
//   BATCH      - lanes per result vector / per DDR beat
//   DDR_W      - DDR data bus width (BATCH * DATA_W)
//   DDR_ADDR_W - DDR byte address width
//   BURST_W    - width of command length and AW burst length fields
//   bw()       - bits needed to encode values 0..value-1
// -----------------------------------------------------------------------------
package GLOBAL_PARAM;

  localparam int DATA_W     = 8;
  localparam int RES_W      = 32;
  localparam int BATCH      = 32;
  localparam int DDR_W      = BATCH * DATA_W;
  localparam int DDR_ADDR_W = 32;
  localparam int BURST_W    = 8;

  function automatic int bw(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // Shift amount covers 0..RES_W-1.
  localparam int SHIFT_W = bw(RES_W);

endpackage

// File: rtl/ddr_wr_ctrl_res_quant.sv
// -----------------------------------------------------------------------------
// res_quant: one lane of the result reducer. Arithmetic right shift of a
// signed RES_W lane, then reduction to DATA_W.
//   lane  - signed result lane
//   shift - arithmetic right-shift amount
//   q     - reduced lane
// Build option WR_SAT_EN: saturate to the signed DATA_W range instead of
// keeping the low DATA_W bits.
// -----------------------------------------------------------------------------
module res_quant
  import GLOBAL_PARAM::*;
(
  input  logic [RES_W-1:0]   lane,
  input  logic [SHIFT_W-1:0] shift,
  output logic [DATA_W-1:0]  q
);

  logic signed [RES_W-1:0] shifted;

  assign shifted = $signed(lane) >>> shift;

`ifdef WR_SAT_EN
  localparam logic signed [RES_W-1:0] Q_MAX = RES_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [RES_W-1:0] Q_MIN = ~Q_MAX;

  // NOTE: every path assigns q, so this stays combinational (no latch).
  always_comb begin
    if (shifted > Q_MAX) begin
      q = Q_MAX[DATA_W-1:0];
    end else if (shifted < Q_MIN) begin
      q = Q_MIN[DATA_W-1:0];
    end else begin
      q = shifted[DATA_W-1:0];
    end
  end
`else
  // Wrap: the upper bits are intentionally discarded.
  logic unused_high;
  assign unused_high = ^shifted[RES_W-1:DATA_W];
  assign q           = shifted[DATA_W-1:0];
`endif

endmodule

// File: rtl/ddr_wr_ctrl.sv
// -----------------------------------------------------------------------------
// ddr_wr_ctrl: turns one write command into a sequence of DDR AW/W bursts,
// feeding each beat from an incoming result vector reduced lane by lane.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   cmd_valid/ready/addr/len/shift - write command (len in beats)
//   in_valid/ready/data         - result vectors, BATCH lanes of RES_W
//   aw_valid/ready/addr/len     - DDR address channel (len = beats - 1)
//   w_valid/ready/data/last     - DDR data channel
//   done                        - one-cycle pulse at command completion
// Parameter MAX_BURST: maximum beats per DDR burst.
// Build option WR_SAT_EN (in res_quant): saturating lane reduction.
// -----------------------------------------------------------------------------
module ddr_wr_ctrl
  import GLOBAL_PARAM::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DDR_ADDR_W-1:0]   cmd_addr,
  input  logic [BURST_W-1:0]      cmd_len,
  input  logic [SHIFT_W-1:0]      cmd_shift,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BATCH*RES_W-1:0]  in_data,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [DDR_ADDR_W-1:0]   aw_addr,
  output logic [BURST_W-1:0]      aw_len,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [DDR_W-1:0]        w_data,
  output logic                    w_last,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam int              BEAT_BYTES_LOG2 = $clog2(DDR_W / 8);
  localparam logic [BURST_W:0] MAX_BEATS      = (BURST_W + 1)'(MAX_BURST);
  localparam logic [BURST_W:0] ONE_BEAT       = (BURST_W + 1)'(1);

  state_t               state;
  logic [BURST_W-1:0]   remaining;   // beats not yet covered by an issued AW
  logic [BURST_W:0]     cap_left;    // vectors still to capture in this burst
  logic [SHIFT_W-1:0]   shift;
  logic [DDR_W-1:0]     quant_data;

  // Lane reducers work straight off in_data; the result is registered into
  // w_data on capture, giving the single-cycle input-to-output latency.
  for (genvar i = 0; i < BATCH; i++) begin : g_lane
    res_quant u_res_quant (
      .lane  (in_data[i*RES_W +: RES_W]),
      .shift (shift),
      .q     (quant_data[i*DATA_W +: DATA_W])
    );
  end

  // Length of the next burst: from the command when leaving IDLE, otherwise
  // from what is left after the previous AW.
  logic [BURST_W-1:0]    len_src;
  logic [BURST_W:0]      next_beats;
  logic [BURST_W-1:0]    next_aw_len;
  logic [BURST_W:0]      cur_beats;
  logic [DDR_ADDR_W-1:0] burst_bytes;
  logic [BURST_W-1:0]    remaining_after;

  assign len_src         = (state == IDLE) ? cmd_len : remaining;
  assign next_beats      = ({1'b0, len_src} > MAX_BEATS) ? MAX_BEATS : {1'b0, len_src};
  assign next_aw_len     = BURST_W'(next_beats - ONE_BEAT);
  assign cur_beats       = {1'b0, aw_len} + ONE_BEAT;
  assign burst_bytes     = DDR_ADDR_W'(cur_beats) << BEAT_BYTES_LOG2;
  assign remaining_after = BURST_W'({1'b0, remaining} - cur_beats);

  logic in_fire;
  logic w_fire;

  // Accept a vector only while this burst still needs one and the output
  // register is free or draining this cycle.
  assign in_ready = (state == DATA) && (cap_left != '0) && (!w_valid || w_ready);
  assign in_fire  = in_valid && in_ready;
  assign w_fire   = w_valid && w_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      aw_valid  <= 1'b0;
      aw_addr   <= '0;
      aw_len    <= '0;
      w_valid   <= 1'b0;
      // NOTE: the wide data register is reset too, so w_data reads zero
      // while in reset; it is a plain flop, not a memory.
      w_data    <= '0;
      w_last    <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      cap_left  <= '0;
      shift     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            aw_addr   <= cmd_addr;
            remaining <= cmd_len;
            shift     <= cmd_shift;
            if (cmd_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ADDR;
              aw_valid <= 1'b1;
              aw_len   <= next_aw_len;
            end
          end
        end

        ADDR: begin
          if (aw_ready) begin
            aw_valid  <= 1'b0;
            aw_addr   <= aw_addr + burst_bytes;
            remaining <= remaining_after;
            cap_left  <= cur_beats;
            state     <= DATA;
          end
        end

        DATA: begin
          if (in_fire) begin
            w_data   <= quant_data;
            w_valid  <= 1'b1;
            w_last   <= (cap_left == ONE_BEAT);
            cap_left <= cap_left - ONE_BEAT;
          end else if (w_fire) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
          end
          // The next AW only issues once this burst's last beat is taken.
          if (w_fire && w_last) begin
            if (remaining != '0) begin
              state    <= ADDR;
              aw_valid <= 1'b1;
              aw_len   <= next_aw_len;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ddr_wr_ctrl: directed bench for ddr_wr_ctrl. A queue-based model predicts
// the AW sequence (burst splitting), the W beats (lane-wise floor division and
// saturate/wrap on each accepted vector) and the w_last pattern; a monitor
// compares every handshake and stall cycle, and directed literals pin the
// model for the listed scenarios. Honours WR_SAT_EN like the RTL.
// -----------------------------------------------------------------------------
module tb_ddr_wr_ctrl;
  import GLOBAL_PARAM::*;

  localparam int MAXB = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [DDR_ADDR_W-1:0]  cmd_addr = '0;
  logic [BURST_W-1:0]     cmd_len = '0;
  logic [SHIFT_W-1:0]     cmd_shift = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [BATCH*RES_W-1:0] in_data = '0;
  logic                   aw_valid;
  logic                   aw_ready = 1'b1;
  logic [DDR_ADDR_W-1:0]  aw_addr;
  logic [BURST_W-1:0]     aw_len;
  logic                   w_valid;
  logic                   w_ready = 1'b1;
  logic [DDR_W-1:0]       w_data;
  logic                   w_last;
  logic                   done;

  always #5 clk = ~clk;

  ddr_wr_ctrl #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_shift(cmd_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DDR_W-1:0] act, input logic [DDR_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [DATA_W-1:0] q_model(input logic [RES_W-1:0] lane, input int s);
    longint v, d, q;
    v = longint'($signed(lane));
    d = longint'(1) << s;
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);   // floor division for negatives
`ifdef WR_SAT_EN
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
`endif
    return DATA_W'(q);
  endfunction

  function automatic logic [DDR_W-1:0] model_vec(input logic [BATCH*RES_W-1:0] v, input int s);
    logic [DDR_W-1:0] r;
    for (int i = 0; i < BATCH; i++) r[i*DATA_W +: DATA_W] = q_model(v[i*RES_W +: RES_W], s);
    return r;
  endfunction

  function automatic logic [BATCH*RES_W-1:0] mk_vec(input int mode, input int base, input int k);
    logic [BATCH*RES_W-1:0] r;
    int lane;
    for (int i = 0; i < BATCH; i++) begin
      lane = (mode == 0) ? base : base + k * 1000 - i * 317;
      r[i*RES_W +: RES_W] = lane;
    end
    return r;
  endfunction

  logic [DDR_W-1:0]      exp_data[$];
  bit                    exp_last[$];
  logic [DDR_ADDR_W-1:0] exp_aw_addr[$];
  int                    exp_aw_len[$];
  logic [DDR_ADDR_W-1:0] aw_addr_log[$];
  int                    aw_len_log[$];

  int               beat_cnt = 0;
  int               done_cnt = 0;
  int               done_base = 0;
  int               last_cnt = 0;
  int               last_idx = 0;
  logic [DDR_W-1:0] first_w = '0;

  int feed_mode = 0;
  int feed_base = 0;
  int feed_total = 0;
  int feed_gen = 0;
  int cur_shift = 0;
  bit rand_ready = 1'b0;

  // ---------------- drivers ----------------
  always begin : ready_drv
    @(posedge clk);
    #1;
    w_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    aw_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always begin : feeder
    bit hs;
    int my_gen;
    int idx;
    @(negedge clk);
    hs = in_valid && in_ready && rst_n;
    @(posedge clk);
    #2;
    if (feed_gen != my_gen) begin
      my_gen = feed_gen;
      idx = 0;
    end else if (hs) begin
      idx++;
    end
    if (rst_n && idx < feed_total) begin
      in_valid = 1'b1;
      in_data  = mk_vec(feed_mode, feed_base, idx);
    end else begin
      in_valid = 1'b0;
    end
  end

  // ---------------- monitor / compare ----------------
  bit               prev_stall = 1'b0;
  logic [DDR_W-1:0] prev_data;
  logic             prev_last;

  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_data.push_back(model_vec(in_data, cur_shift));
      if (prev_stall) begin
        check("w_valid_hold", w_valid, 1);
        check("w_data_hold", w_data, prev_data);
        check("w_last_hold", w_last, prev_last);
      end
      if (w_valid && !w_ready) check("in_ready_stall", in_ready, 0);
      if (aw_valid) begin
        check("aw_w_overlap", w_valid, 0);
        check("in_ready_addr", in_ready, 0);
      end
      if (cmd_ready) check("cmd_ready_busy", {aw_valid, w_valid, done}, 0);
      if (aw_valid && aw_ready) begin
        aw_addr_log.push_back(aw_addr);
        aw_len_log.push_back(int'(aw_len));
        check("aw_expected", exp_aw_addr.size() != 0, 1);
        if (exp_aw_addr.size() != 0) begin
          check("aw_addr", aw_addr, exp_aw_addr.pop_front());
          check("aw_len", aw_len, exp_aw_len.pop_front());
        end
      end
      if (w_valid && w_ready) begin
        beat_cnt++;
        if (beat_cnt == 1) first_w = w_data;
        if (w_last) begin
          last_cnt++;
          last_idx = beat_cnt;
        end
        check("w_expected", (exp_data.size() != 0) && (exp_last.size() != 0), 1);
        if (exp_data.size() != 0) check("w_data", w_data, exp_data.pop_front());
        if (exp_last.size() != 0) check("w_last", w_last, exp_last.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("done_after_all_beats", exp_last.size(), 0);
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      prev_last  = w_last;
    end
  end

  // ---------------- command tasks ----------------
  task automatic start_cmd(input logic [DDR_ADDR_W-1:0] addr, input int len, input int shift,
                           input int mode, input int base);
    int rem;
    int b;
    int wait_cyc;
    logic [DDR_ADDR_W-1:0] a;
    rem = len;
    a = addr;
    while (rem > 0) begin
      b = (rem > MAXB) ? MAXB : rem;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(b - 1);
      for (int j = 0; j < b; j++) exp_last.push_back(1'(j == b - 1));
      a = a + DDR_ADDR_W'(b * (DDR_W / 8));
      rem -= b;
    end
    exp_data.delete();
    aw_addr_log.delete();
    aw_len_log.delete();
    beat_cnt = 0;
    last_cnt = 0;
    last_idx = 0;
    first_w = '0;
    done_base = done_cnt;
    cur_shift = shift;
    feed_mode = mode;
    feed_base = base;
    feed_total = len;
    feed_gen++;
    cmd_addr = addr;
    cmd_len = BURST_W'(len);
    cmd_shift = SHIFT_W'(shift);
    cmd_valid = 1'b1;
    wait_cyc = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      wait_cyc++;
      if (wait_cyc > 100) break;
    end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int len);
    int cnt;
    cnt = 0;
    while (done_cnt == done_base && cnt < 3000) begin
      @(posedge clk);
      cnt++;
    end
    check({tag, "_done_seen"}, done_cnt != done_base, 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt - done_base, 1);
    check({tag, "_beats"}, beat_cnt, len);
    check({tag, "_bursts"}, aw_addr_log.size(), (len + MAXB - 1) / MAXB);
    check({tag, "_aw_drained"}, exp_aw_addr.size(), 0);
    check({tag, "_w_drained"}, exp_data.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  logic [DDR_W-1:0] exp_w;
  logic [DATA_W-1:0] exp_b;
  int cnt;

  initial begin : main
    repeat (3) @(negedge clk);
    check("reset_ctrl", {aw_valid, w_valid, w_last, done, in_ready, cmd_ready}, 0);
    check("reset_aw_addr", aw_addr, 0);
    check("reset_aw_len", aw_len, 0);
    check("reset_w_data", w_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_cmd_ready", cmd_ready, 1);

    // Model pins
`ifdef WR_SAT_EN
    check("model_pin_pos", q_model(32'h0000_1000, 4), 8'h7F);
    check("model_pin_neg", q_model(32'hFFFF_FE00, 0), 8'h80);
`else
    check("model_pin_pos", q_model(32'h0000_1000, 4), 8'h00);
    check("model_pin_neg", q_model(32'hFFFF_FE00, 0), 8'h00);
`endif
    check("model_pin_floor", q_model(32'hFFFF_FFFF, 4), 8'hFF);

    // Basic 3-beat command, lanes = 5
    start_cmd(32'h0000_1000, 3, 0, 0, 5);
    finish_cmd("basic", 3);
    check("basic_aw_addr", aw_addr_log.size() > 0 ? aw_addr_log[0] : 32'hDEAD_BEEF, 32'h0000_1000);
    check("basic_aw_len", aw_len_log.size() > 0 ? aw_len_log[0] : -1, 2);
    exp_w = {BATCH{8'h05}};
    check("basic_w_data", first_w, exp_w);
    check("basic_last_cnt", last_cnt, 1);
    check("basic_last_idx", last_idx, 3);

    // 40 beats split into 16/16/8
    start_cmd(32'h0000_0000, 40, 3, 1, -5000);
    finish_cmd("long", 40);
    check("long_n_aw", aw_addr_log.size(), 3);
    if (aw_addr_log.size() == 3) begin
      check("long_aw0_addr", aw_addr_log[0], 32'h0000_0000);
      check("long_aw0_len", aw_len_log[0], 15);
      check("long_aw1_addr", aw_addr_log[1], 32'h0000_0200);
      check("long_aw1_len", aw_len_log[1], 15);
      check("long_aw2_addr", aw_addr_log[2], 32'h0000_0400);
      check("long_aw2_len", aw_len_log[2], 7);
    end
    check("long_last_cnt", last_cnt, 3);

    // Reduction boundaries
`ifdef WR_SAT_EN
    exp_b = 8'h7F;
`else
    exp_b = 8'h00;
`endif
    start_cmd(32'h0000_2000, 1, 4, 0, 32'h0000_1000);
    finish_cmd("sat_pos", 1);
    exp_w = {BATCH{exp_b}};
    check("sat_pos_w_data", first_w, exp_w);
`ifdef WR_SAT_EN
    exp_b = 8'h80;
`else
    exp_b = 8'h00;
`endif
    start_cmd(32'h0000_2020, 1, 0, 0, -512);
    finish_cmd("sat_neg", 1);
    exp_w = {BATCH{exp_b}};
    check("sat_neg_w_data", first_w, exp_w);

    // Random back-pressure
    rand_ready = 1'b1;
    start_cmd(32'h0000_3000, 5, 2, 1, 100);
    finish_cmd("stall", 5);
    check("stall_last_idx", last_idx, 5);
    start_cmd(32'h0000_4000, 20, 7, 1, -20000);
    finish_cmd("stall_multi", 20);
    check("stall_multi_last_cnt", last_cnt, 2);
    rand_ready = 1'b0;

    // Zero-length command
    start_cmd(32'h0000_5000, 0, 0, 0, 0);
    @(negedge clk);
    check("zero_done_pulse", done, 1);
    check("zero_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("zero_cmd_ready_back", cmd_ready, 1);
    check("zero_done_low", done, 0);
    finish_cmd("zero", 0);

    // Reset during beat 2 of 4
    start_cmd(32'h0000_6000, 4, 1, 1, 300);
    cnt = 0;
    while (beat_cnt < 1 && cnt < 200) begin
      @(posedge clk);
      cnt++;
    end
    check("midrst_beat1_seen", beat_cnt >= 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {aw_valid, w_valid, w_last, done, in_ready, cmd_ready}, 0);
    feed_total = 0;
    feed_gen++;
    exp_data.delete();
    exp_last.delete();
    exp_aw_addr.delete();
    exp_aw_len.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_no_partial", {aw_valid, w_valid}, 0);
    end
    @(posedge clk);
    #1;
    start_cmd(32'h0000_7000, 4, 1, 1, 300);
    finish_cmd("after_rst", 4);
    check("after_rst_aw_addr", aw_addr_log.size() > 0 ? aw_addr_log[0] : 32'hDEAD_BEEF, 32'h0000_7000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_wr_ctrl.md
DDR_WR_CTRL -- requirements
Module: ddr_wr_ctrl

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, the maximum number of beats per DDR write burst (1..2^BURST_W).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have cmd_valid, input, 1, write command valid.
REQ-005 SHALL have cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-006 SHALL have cmd_addr, input, DDR_ADDR_W, start byte address, 32-byte aligned.
REQ-007 SHALL have cmd_len, input, BURST_W, total beats to write.
REQ-008 SHALL have cmd_shift, input, bw(RES_W), right-shift applied to each result lane.
REQ-009 SHALL have in_valid, input, 1; in_ready, output, 1; in_data, input, BATCH*RES_W, one result vector, lane i at bits [i*RES_W +: RES_W].
REQ-010 SHALL have aw_valid, output, 1; aw_ready, input, 1; aw_addr, output, DDR_ADDR_W; aw_len, output, BURST_W (beats minus 1).
REQ-011 SHALL have w_valid, output, 1; w_ready, input, 1; w_data, output, DDR_W; w_last, output, 1.
REQ-012 SHALL have done, output, 1, one-cycle pulse when a command completes.

Function
REQ-013 SHALL implement states IDLE, ADDR, DATA, DONE.
REQ-014 IDLE: cmd_ready=1; on cmd_valid latch addr/len/shift; go to ADDR, or to DONE if cmd_len==0 (no DDR traffic).
REQ-015 ADDR: aw_valid=1, aw_len=min(remaining, MAX_BURST)-1; on aw_ready go to DATA, advance address by burst_beats*DDR_W/8.
REQ-016 DATA: in_ready = !w_valid || w_ready; accepted vector appears on w_data the next cycle (latency 1, single output register, no bubble under continuous ready).
REQ-017 Each lane SHALL be arithmetically right-shifted by cmd_shift, then reduced to DATA_W; lane i to w_data[i*DATA_W +: DATA_W] (BATCH*DATA_W == DDR_W).
REQ-018 w_last SHALL be asserted on the final beat of each burst; w_data/w_last SHALL hold while w_valid && !w_ready.
REQ-019 On w_last accepted: if remaining beats > 0 go to ADDR, else DONE; next AW SHALL not issue before previous burst's last beat is accepted.
REQ-020 DONE: done=1 for one cycle, then IDLE; cmd_ready=0 in all states except IDLE.
REQ-021 in_ready SHALL be 0 outside DATA and after the burst's final beat is captured.

Reset
REQ-022 On rst_n low, state SHALL be IDLE and aw_valid, w_valid, w_last, done, in_ready SHALL be 0, cmd_ready 0 during reset; counters and address cleared.
REQ-023 Reset mid-burst SHALL abandon the command; no partial beat issued after release.

Configuration
REQ-024 With WR_SAT_EN defined, reduction SHALL saturate to signed DATA_W range [-128,127].
REQ-025 Without WR_SAT_EN, reduction SHALL keep the low DATA_W bits (wrap).

Structure
REQ-026 DATA_W, RES_W, BATCH, DDR_W, DDR_ADDR_W, BURST_W and bw() SHALL come from GLOBAL_PARAM; state enum typedef local.
REQ-027 The per-lane shift-and-reduce SHALL be sub-module res_quant, instantiated BATCH times.

Verification
REQ-028 cmd_addr=0x1000, len=3, shift=0, lanes=5, always ready -> one AW addr 0x1000 len 2, three beats of bytes 0x05, w_last on beat 3, done once.
REQ-029 len=40, MAX_BURST=16 -> AW 0x0 len 15, 0x200 len 15, 0x400 len 7; 40 beats total.
REQ-030 lane=0x00001000, shift=4 -> 0x0100: WR_SAT_EN gives 0x7F, without gives 0x00; lane=-512, shift=0 -> 0x80 / 0x00.
REQ-031 w_ready toggled randomly, len=5 -> w_data stable under stall, no lost/duplicated vector, done after 5th beat.
REQ-032 cmd_len=0 -> no aw_valid, done pulse, cmd_ready high again 2 cycles after accept.
REQ-033 rst_n low during beat 2 of 4 -> all outputs 0; new command after release runs cleanly.
